// File: rtl/alt_dprio_serial.sv
// alt_dprio_serial
//   Serial DPRIO master. Takes one parallel read/write request at a time and
//   serialises it onto dprioin. A request is sent as an optional address frame,
//   then a gap, then a data frame. Each frame is a run of preamble ones followed
//   by a 29-bit body: ST(2) OP(2) QUAD(7) TA(2) DATA(16), sent MSB first.
//   Read data is shifted in from dprioout during the DATA field of a read frame.
//
// Ports
//   clock, reset      reconfig clock; synchronous active-high reset
//   addr, quad_addr   register address and quad select of the request
//   datain            write data
//   wren, rden        request strobes, accepted only while busy=0
//                     (both high is treated as a write)
//   retain_addr       skip the address frame if that address is already latched
//   dataout           data from the most recent completed read
//   busy              transaction in progress
//   dprioin           serial output to the transceiver
//   dprioout          serial input from the transceiver
//   dprioload         write-commit strobe, one bit time after a write frame
//   dpriodisable      high while the port is idle
//
// Optional feature (macro ALT_DPRIO_WRITE_VERIFY_EN)
//   Each write is followed by an automatic read-back frame, with no address
//   frame. The read-back updates dataout. A sticky write_error output is set
//   when the read-back differs from the written data. It is cleared by reset
//   or by the next accepted write.

module alt_dprio_serial #(
  parameter int CLK_DIV      = 1,
  parameter int PREAMBLE_LEN = 32,
  parameter int GAP_BITS     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [6:0]  quad_addr,
  input  logic [15:0] datain,
  input  logic        wren,
  input  logic        rden,
  input  logic        retain_addr,
  output logic [15:0] dataout,
  output logic        busy,
  output logic        dprioin,
  input  logic        dprioout,
  output logic        dprioload,
  output logic        dpriodisable
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
  ,
  output logic        write_error
`endif
);

  // The counter covers the longest preamble (63 bits), the 29-bit body and the gap.
  localparam int CNT_MAX = (GAP_BITS > 64) ? GAP_BITS : 64;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] BODY_LAST  = CNT_W'(28);
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(13);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [3:0]       DIV_LAST   = 4'(CLK_DIV - 1);

  // CAPTURE is zero-length, so it has no state of its own. It is folded into
  // the DATA_BODY -> IDLE transition, where dataout is written.
  typedef enum logic [2:0] {
    IDLE, ADDR_PRE, ADDR_BODY, GAP, DATA_PRE, DATA_BODY, LOAD
  } state_t;

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [3:0]       div;
  logic             is_write, addr_vld, rd_frame, bit_end, nbit, skip_addr;
  logic [15:0]      addr_q, data_q, rdata;
  logic [6:0]       quad_q;
  logic [14:0]      shreg;
  logic [28:0]      addr_frame, data_frame;

  function automatic logic [28:0] build_frame(input logic [1:0]  op,
                                              input logic [6:0]  quad,
                                              input logic [1:0]  ta,
                                              input logic [15:0] data);
    return {2'b00, op, quad, ta, data};
  endfunction

`ifdef ALT_DPRIO_WRITE_VERIFY_EN
  logic verify;
  assign rd_frame = ~is_write | verify;
`else
  assign rd_frame = ~is_write;
`endif

  assign addr_frame = build_frame(2'b00, quad_q, 2'b11, addr_q);
  assign data_frame = rd_frame ? build_frame(2'b11, quad_q, 2'b11, 16'hFFFF)
                               : build_frame(2'b01, quad_q, 2'b10, data_q);
  assign bit_end    = (div == DIV_LAST);
  assign rdata      = {shreg, dprioout};
  assign skip_addr  = retain_addr & addr_vld & (addr == addr_q) & (quad_addr == quad_q);

  // Select the next bit slot and the dprioin value it drives. The value is
  // registered at the bit boundary, so dprioin changes only between bit times.
  always_comb begin
    nstate = state;
    ncnt   = cnt + CNT_ONE;
    case (state)
      ADDR_PRE:  if (cnt == PRE_LAST)  begin nstate = ADDR_BODY; ncnt = '0; end
      ADDR_BODY: if (cnt == BODY_LAST) begin
                   nstate = (GAP_BITS > 0) ? GAP : DATA_PRE;
                   ncnt   = '0;
                 end
      GAP:       if (cnt == GAP_LAST)  begin nstate = DATA_PRE;  ncnt = '0; end
      DATA_PRE:  if (cnt == PRE_LAST)  begin nstate = DATA_BODY; ncnt = '0; end
      DATA_BODY: if (cnt == BODY_LAST) begin
                   nstate = rd_frame ? IDLE : LOAD;
                   ncnt   = '0;
                 end
      LOAD: begin
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
        nstate = DATA_PRE;
`else
        nstate = IDLE;
`endif
        ncnt = '0;
      end
      default: begin nstate = IDLE; ncnt = '0; end
    endcase

    case (nstate)
      ADDR_BODY: nbit = addr_frame[5'd28 - ncnt[4:0]];
      DATA_BODY: nbit = data_frame[5'd28 - ncnt[4:0]];
      default:   nbit = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      div          <= '0;
      busy         <= 1'b0;
      dprioin      <= 1'b1;
      dprioload    <= 1'b0;
      dpriodisable <= 1'b1;
      dataout      <= 16'h0000;
      addr_vld     <= 1'b0;
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
      verify       <= 1'b0;
      write_error  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (wren | rden) begin
        addr_q       <= addr;
        quad_q       <= quad_addr;
        data_q       <= datain;
        is_write     <= wren;
        busy         <= 1'b1;
        dpriodisable <= 1'b0;
        dprioin      <= 1'b1;
        div          <= '0;
        cnt          <= '0;
        if (skip_addr) begin
          state <= DATA_PRE;
        end else begin
          state    <= ADDR_PRE;
          addr_vld <= 1'b1;
        end
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
        verify <= 1'b0;
        if (wren) write_error <= 1'b0;
`endif
      end
    end else if (bit_end) begin
      div       <= '0;
      state     <= nstate;
      cnt       <= ncnt;
      dprioin   <= nbit;
      dprioload <= (nstate == LOAD);
      if (nstate == IDLE) begin
        busy         <= 1'b0;
        dpriodisable <= 1'b1;
      end
      // dprioout is sampled on the last clock of each DATA-field bit.
      if (state == DATA_BODY && cnt >= DATA_FIRST) shreg <= rdata[14:0];
      if (state == DATA_BODY && cnt == BODY_LAST && rd_frame) begin
        dataout <= rdata;
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
        if (verify && rdata != data_q) write_error <= 1'b1;
`endif
      end
`ifdef ALT_DPRIO_WRITE_VERIFY_EN
      if (state == LOAD) verify <= 1'b1;
`endif
    end else begin
      div <= div + 4'd1;
    end
  end

endmodule
